// File: rtl/dla_rx_datapath_pkg.sv
// Shared flit-format constants and decode helper for the die-to-die RX datapath.
package dla_rx_datapath_pkg;

  localparam int unsigned NBYTES     = 32;
  localparam int unsigned FLIT_W     = NBYTES * 8;
  localparam int unsigned DATA_LSB   = 125;
  localparam int unsigned DATA_MSB   = FLIT_W - 1;
  localparam int unsigned DLA_DATA_W = FLIT_W - DATA_LSB;
  localparam int unsigned DATA_BIT   = 120;

  localparam logic [FLIT_W-1:0] CRD_BIT_MASK  = FLIT_W'(1);
  localparam logic [FLIT_W-1:0] ALCT_BIT_MASK = FLIT_W'(2);

  typedef struct packed {
    logic [DLA_DATA_W-1:0] data;
    logic                  is_data;
    logic                  is_crd;
    logic                  is_alct;
  } flit_fields_t;

  // Flags are independent; a single flit may carry any combination.
  function automatic flit_fields_t decode_flit(input logic [FLIT_W-1:0] flit);
    flit_fields_t f;
    f.data    = flit[DATA_MSB:DATA_LSB];
    f.is_data = flit[DATA_BIT];
    f.is_crd  = |(flit & CRD_BIT_MASK);
    f.is_alct = |(flit & ALCT_BIT_MASK);
    return f;
  endfunction

endpackage

// File: rtl/dla_crd_cnt.sv
// Saturating up/down credit counter; simultaneous inc and dec cancel out.
module dla_crd_cnt #(
  parameter int unsigned MAX  = 8,
  parameter int unsigned INIT = 8,
  parameter int unsigned W    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         nonzero,
  output logic         overflow,
  output logic         underflow
);

  logic at_max;
  logic at_zero;

  // Boundary flags: a lone inc at MAX or a lone dec at zero is refused.
  always_comb begin
    at_max    = (count == W'(MAX));
    at_zero   = (count == '0);
    nonzero   = !at_zero;
    overflow  = inc && !dec && at_max;
    underflow = dec && !inc && at_zero;
  end

  // Count register with saturation at both ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= W'(INIT);
    end else if (inc && !dec && !at_max) begin
      count <= count + W'(1);
    end else if (dec && !inc && !at_zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/dla_rx_datapath.sv
// RX datapath of the die-to-die link: two-stage flit decode, TX credit pool
// and pending credit-return tracking.
// Optional checker: define DLA_RX_CHK_EN to enable the sticky err_o protocol checks.
module dla_rx_datapath
  import dla_rx_datapath_pkg::*;
#(
  parameter int unsigned TX_CREDITS = 8,
  parameter int unsigned RX_CREDITS = 8,
  localparam int unsigned CNT_W =
    $clog2(((TX_CREDITS > RX_CREDITS) ? TX_CREDITS : RX_CREDITS) + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [FLIT_W-1:0]     pl_data,
  input  logic                  pl_valid,
  output logic                  rx_push_o,
  output logic [DLA_DATA_W-1:0] rx_data_o,
  input  logic                  rx_fifo_full_i,
  input  logic                  rx_fifo_pop_i,
  output logic                  rx_crd_o,
  input  logic                  rx_crd_ready_i,
  input  logic                  tx_cmd_fire_i,
  output logic                  tx_crd_avail_o,
  output logic [CNT_W-1:0]      tx_crd_cnt_o,
  output logic                  alct_grant_o,
  output logic                  err_o
);

  logic         s1_valid;
  flit_fields_t s1_flit;
  logic         s2_crd;

  logic             tx_inc, tx_dec, tx_ovf, tx_udf;
  logic             pend_inc, pend_dec, pend_nonzero, pend_ovf, pend_udf;
  logic [CNT_W-1:0] pend_cnt;

  // Stage 1: capture incoming flit; flits arriving while disabled are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_flit  <= '0;
    end else begin
      s1_valid <= pl_valid && enable;
      if (pl_valid && enable) begin
        s1_flit <= decode_flit(pl_data);
      end
    end
  end

  // Stage 2: registered decode outputs; push is issued even if the FIFO is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_push_o    <= 1'b0;
      rx_data_o    <= '0;
      alct_grant_o <= 1'b0;
      s2_crd       <= 1'b0;
    end else begin
      rx_push_o    <= s1_valid && s1_flit.is_data;
      alct_grant_o <= s1_valid && s1_flit.is_alct;
      s2_crd       <= s1_valid && s1_flit.is_crd;
      if (s1_valid && s1_flit.is_data) begin
        rx_data_o <= s1_flit.data;
      end
    end
  end

  // Counter controls; everything holds while the block is disabled.
  always_comb begin
    tx_inc   = enable && s2_crd;
    tx_dec   = enable && tx_cmd_fire_i;
    pend_inc = enable && rx_fifo_pop_i;
    rx_crd_o = enable && pend_nonzero;
    pend_dec = rx_crd_o && rx_crd_ready_i;
  end

  dla_crd_cnt #(
    .MAX  (TX_CREDITS),
    .INIT (TX_CREDITS),
    .W    (CNT_W)
  ) u_tx_pool (
    .clk       (clk),
    .rst       (rst),
    .inc       (tx_inc),
    .dec       (tx_dec),
    .count     (tx_crd_cnt_o),
    .nonzero   (tx_crd_avail_o),
    .overflow  (tx_ovf),
    .underflow (tx_udf)
  );

  dla_crd_cnt #(
    .MAX  (RX_CREDITS),
    .INIT (0),
    .W    (CNT_W)
  ) u_pend_ret (
    .clk       (clk),
    .rst       (rst),
    .inc       (pend_inc),
    .dec       (pend_dec),
    .count     (pend_cnt),
    .nonzero   (pend_nonzero),
    .overflow  (pend_ovf),
    .underflow (pend_udf)
  );

`ifdef DLA_RX_CHK_EN
  // Sticky protocol error on any refused counter step or a push into a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (tx_udf || tx_ovf || pend_ovf || (rx_push_o && rx_fifo_full_i)) begin
      err_o <= 1'b1;
    end
  end

  logic unused_sink;
  assign unused_sink = ^{pl_data[DATA_LSB-1:DATA_BIT+1], pl_data[DATA_BIT-1:2],
                         pend_udf, pend_cnt};
`else
  assign err_o = 1'b0;

  logic unused_sink;
  assign unused_sink = ^{pl_data[DATA_LSB-1:DATA_BIT+1], pl_data[DATA_BIT-1:2],
                         pend_udf, pend_cnt, tx_ovf, tx_udf, pend_ovf, rx_fifo_full_i};
`endif

endmodule

// File: tb/tb_dla_rx_datapath.sv
// Scoreboard bench for dla_rx_datapath: stimulus pushes expected FIFO/grant
// outputs, a negedge monitor pops and compares whenever the DUT emits one.
module tb_dla_rx_datapath;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [255:0] pl_data;
  logic         pl_valid;
  logic         rx_push_o;
  logic [130:0] rx_data_o;
  logic         rx_fifo_full_i;
  logic         rx_fifo_pop_i;
  logic         rx_crd_o;
  logic         rx_crd_ready_i;
  logic         tx_cmd_fire_i;
  logic         tx_crd_avail_o;
  logic [3:0]   tx_crd_cnt_o;
  logic         alct_grant_o;
  logic         err_o;

`ifdef DLA_RX_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    int           cyc;
    logic [130:0] data;
    bit           push;
    bit           alct;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  bit   exp_err;

  dla_rx_datapath #(.TX_CREDITS(8), .RX_CREDITS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .pl_data        (pl_data),
    .pl_valid       (pl_valid),
    .rx_push_o      (rx_push_o),
    .rx_data_o      (rx_data_o),
    .rx_fifo_full_i (rx_fifo_full_i),
    .rx_fifo_pop_i  (rx_fifo_pop_i),
    .rx_crd_o       (rx_crd_o),
    .rx_crd_ready_i (rx_crd_ready_i),
    .tx_cmd_fire_i  (tx_cmd_fire_i),
    .tx_crd_avail_o (tx_crd_avail_o),
    .tx_crd_cnt_o   (tx_crd_cnt_o),
    .alct_grant_o   (alct_grant_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every DUT output event must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && (rx_push_o || alct_grant_o)) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output cyc=%0d push=%b alct=%b data=%h, required no output",
                 cyc, rx_push_o, alct_grant_o, rx_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.push != rx_push_o || e.alct != alct_grant_o ||
            (e.push && e.data != rx_data_o)) begin
          fails++;
          $display("FAIL sb_output got cyc=%0d push=%b alct=%b data=%h, required cyc=%0d push=%b alct=%b data=%h",
                   cyc, rx_push_o, alct_grant_o, rx_data_o, e.cyc, e.push, e.alct, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [131:0] act, input logic [131:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] mk(input logic [130:0] d, input bit dat, input bit crd, input bit alct);
    logic [255:0] f;
    f = '0;
    f[255:125] = d;
    f[120] = dat;
    f[0] = crd;
    f[1] = alct;
    return f;
  endfunction

  // Drive one flit for one cycle; exp_out says whether an output event is expected.
  task automatic send(input logic [130:0] d, input bit dat, input bit crd, input bit alct, input bit exp_out);
    exp_t e;
    pl_valid = 1'b1;
    pl_data  = mk(d, dat, crd, alct);
    if (exp_out) begin
      e.cyc = cyc + 2; e.data = d; e.push = dat; e.alct = alct;
      exp_q.push_back(e);
    end
    tick();
  endtask

  task automatic idle(input int n);
    pl_valid = 1'b0;
    pl_data  = '0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_err = 1'b0;
  endtask

  int hs;
  int hi;

  initial begin
    rst = 1'b1; enable = 1'b1; pl_data = '0; pl_valid = 1'b0;
    rx_fifo_full_i = 1'b0; rx_fifo_pop_i = 1'b0; rx_crd_ready_i = 1'b0; tx_cmd_fire_i = 1'b0;
    exp_err = 1'b0;
    tick(); tick();
    chk("rst_cnt", 132'(tx_crd_cnt_o), 132'd8);
    chk("rst_avail", 132'(tx_crd_avail_o), 132'd1);
    chk("rst_rx_crd", 132'(rx_crd_o), 132'd0);
    chk("rst_err", 132'(err_o), 132'd0);
    chk("rst_push", 132'(rx_push_o), 132'd0);
    chk("rst_data", 132'(rx_data_o), 132'd0);
    rst = 1'b0;
    tick();

    // Single DATA flit
    send(131'h5A, 1, 0, 0, 1);
    idle(4);
    chk("data_cnt_unchanged", 132'(tx_crd_cnt_o), 132'd8);

    // Drain the TX pool, then one more fire at zero
    tx_cmd_fire_i = 1'b1;
    repeat (8) tick();
    chk("drain_cnt", 132'(tx_crd_cnt_o), 132'd0);
    chk("drain_avail", 132'(tx_crd_avail_o), 132'd0);
    chk("drain_err", 132'(err_o), 132'd0);
    tick();
    exp_err = CHK;
    tx_cmd_fire_i = 1'b0;
    chk("underflow_cnt", 132'(tx_crd_cnt_o), 132'd0);
    chk("underflow_err", 132'(err_o), 132'(exp_err));

    // Three CRD flits then CRD|ALCT|DATA back-to-back
    send('0, 0, 1, 0, 0);
    send('0, 0, 1, 0, 0);
    send('0, 0, 1, 0, 0);
    send(131'h1234_5678_9ABC, 1, 1, 1, 1);
    idle(1);
    chk("combo_cnt_n2", 132'(tx_crd_cnt_o), 132'd3);
    tick();
    chk("combo_cnt_n3", 132'(tx_crd_cnt_o), 132'd4);
    chk("combo_avail", 132'(tx_crd_avail_o), 132'd1);
    idle(2);

    // Three pops with the write datapath stalling for two cycles
    hs = 0; hi = 0;
    for (int t = 0; t < 10; t++) begin
      rx_fifo_pop_i  = (t < 3);
      rx_crd_ready_i = (t >= 3);
      if (rx_crd_o && rx_crd_ready_i) hs++;
      tick();
      if (rx_crd_o) hi++;
    end
    rx_crd_ready_i = 1'b0;
    chk("ret_high_cycles", 132'(hi), 132'd5);
    chk("ret_handshakes", 132'(hs), 132'd3);
    chk("ret_idle", 132'(rx_crd_o), 132'd0);

    // Pending saturation: 9 pops, then drain
    rx_fifo_pop_i = 1'b1;
    repeat (9) tick();
    rx_fifo_pop_i = 1'b0;
    exp_err = CHK;
    chk("pend_sat_err", 132'(err_o), 132'(exp_err));
    rx_crd_ready_i = 1'b1;
    hs = 0;
    for (int t = 0; t < 12; t++) begin
      if (rx_crd_o) hs++;
      tick();
    end
    rx_crd_ready_i = 1'b0;
    chk("pend_sat_handshakes", 132'(hs), 132'd8);

    // Disabled: flits, fires and pops all ignored
    enable = 1'b0;
    tx_cmd_fire_i = 1'b1; rx_fifo_pop_i = 1'b1;
    send(131'h77, 1, 1, 1, 0);
    send(131'h78, 1, 1, 0, 0);
    tx_cmd_fire_i = 1'b0; rx_fifo_pop_i = 1'b0;
    idle(3);
    chk("dis_cnt", 132'(tx_crd_cnt_o), 132'd4);
    chk("dis_rx_crd", 132'(rx_crd_o), 132'd0);
    enable = 1'b1;
    tick();
    chk("reen_rx_crd", 132'(rx_crd_o), 132'd0);

    // CRD at full pool
    do_reset();
    chk("post_rst_err", 132'(err_o), 132'd0);
    send('0, 0, 1, 0, 0);
    idle(3);
    exp_err = CHK;
    chk("full_pool_cnt", 132'(tx_crd_cnt_o), 132'd8);
    chk("full_pool_err", 132'(err_o), 132'(exp_err));

    // DATA while RX FIFO full: push still issued
    do_reset();
    rx_fifo_full_i = 1'b1;
    send(131'hABC, 1, 0, 0, 1);
    idle(3);
    rx_fifo_full_i = 1'b0;
    exp_err = CHK;
    chk("fifo_full_err", 132'(err_o), 132'(exp_err));

    // Reset mid-stream: in-flight flit, TX fire and pending return flushed
    tx_cmd_fire_i = 1'b1; rx_fifo_pop_i = 1'b1;
    send(131'h99, 1, 1, 1, 0);
    tx_cmd_fire_i = 1'b0; rx_fifo_pop_i = 1'b0;
    pl_valid = 1'b0; pl_data = '0;
    rst = 1'b1;
    tick();
    chk("midrst_push", 132'(rx_push_o), 132'd0);
    chk("midrst_data", 132'(rx_data_o), 132'd0);
    chk("midrst_alct", 132'(alct_grant_o), 132'd0);
    chk("midrst_cnt", 132'(tx_crd_cnt_o), 132'd8);
    chk("midrst_rx_crd", 132'(rx_crd_o), 132'd0);
    chk("midrst_err", 132'(err_o), 132'd0);
    rst = 1'b0;
    idle(3);
    chk("midrst_pend_gone", 132'(rx_crd_o), 132'd0);
    chk("midrst_cnt_after", 132'(tx_crd_cnt_o), 132'd8);

    chk("sb_empty", 132'(exp_q.size()), 132'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
